// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the CPU data port and
// an auxiliary master (loader/DMA/debug). The CPU has fixed priority, a
// starvation timer forces an aux grant, and an aux lock holds the RAM for
// bursts. Read data is registered and returned one cycle after the grant.
// Optional feature macro: ARB_STATS_EN adds per-port stall counters.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no grant last cycle
// CPU_OWN    | CPU was granted last cycle
// AUX_OWN    | aux was granted last cycle without lock
// AUX_LOCKED | aux holds the RAM; the CPU is blocked until the lock drops
module dmem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    input  logic          aux_lock,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
`ifdef ARB_STATS_EN
    output logic [15:0]   cpu_stall_cnt,
    output logic [15:0]   aux_stall_cnt,
`endif
    output logic          MemWrite,
    output logic          MemRead,
    output logic [AW-1:0] address,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data
);

    typedef enum logic [1:0] {IDLE, CPU_OWN, AUX_OWN, AUX_LOCKED} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t        state_q, state_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          aux_rvalid_q, aux_rvalid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] aux_rdata_q, aux_rdata_d;
    logic          cpu_win, aux_win;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        cpu_win = 1'b0;
        aux_win = 1'b0;
        if (!RSTn) begin
            cpu_win = 1'b0;
        end else if (state_q == AUX_LOCKED) begin
            aux_win = aux_req;
        end else if (aux_req && (wait_cnt_q == MAX_WAIT_C)) begin
            aux_win = 1'b1;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
        end else if (aux_req) begin
            aux_win = 1'b1;
        end
    end

    assign cpu_gnt = cpu_win;
    assign aux_gnt = aux_win;

    // RAM drive from the winning port; all zero when idle.
    always_comb begin
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        address    = '0;
        write_data = '0;
        if (cpu_win) begin
            MemWrite   = cpu_we;
            MemRead    = ~cpu_we;
            address    = cpu_addr;
            write_data = cpu_wdata;
        end else if (aux_win) begin
            MemWrite   = aux_we;
            MemRead    = ~aux_we;
            address    = aux_addr;
            write_data = aux_wdata;
        end
    end

    // Next state, starvation timer and read-return capture.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = 8'd0;
        cpu_rvalid_d = cpu_win & ~cpu_we;
        aux_rvalid_d = aux_win & ~aux_we;
        cpu_rdata_d  = (cpu_win && !cpu_we) ? read_data : cpu_rdata_q;
        aux_rdata_d  = (aux_win && !aux_we) ? read_data : aux_rdata_q;

        if (aux_req && !aux_win) begin
            wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 8'd1;
        end

        if (aux_win) begin
            state_d = aux_lock ? AUX_LOCKED : AUX_OWN;
        end else if (cpu_win) begin
            state_d = CPU_OWN;
        end else if ((state_q == AUX_LOCKED) && aux_lock) begin
            state_d = AUX_LOCKED;
        end else begin
            state_d = IDLE;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            cpu_rvalid_q <= 1'b0;
            aux_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            aux_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            aux_rvalid_q <= aux_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            aux_rdata_q  <= aux_rdata_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign aux_rvalid = aux_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign aux_rdata  = aux_rdata_q;

`ifdef ARB_STATS_EN
    logic [15:0] cpu_stall_q, cpu_stall_d;
    logic [15:0] aux_stall_q, aux_stall_d;

    // Saturating stall counters: cycles spent requesting without a grant.
    always_comb begin
        cpu_stall_d = cpu_stall_q;
        aux_stall_d = aux_stall_q;
        if (cpu_req && !cpu_win && (cpu_stall_q != 16'hFFFF)) begin
            cpu_stall_d = cpu_stall_q + 16'd1;
        end
        if (aux_req && !aux_win && (aux_stall_q != 16'hFFFF)) begin
            aux_stall_d = aux_stall_q + 16'd1;
        end
    end

    // Stall counter registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cpu_stall_q <= 16'd0;
            aux_stall_q <= 16'd0;
        end else begin
            cpu_stall_q <= cpu_stall_d;
            aux_stall_q <= aux_stall_d;
        end
    end

    assign cpu_stall_cnt = cpu_stall_q;
    assign aux_stall_cnt = aux_stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural RAM model.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          aux_req, aux_we, aux_lock;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_gnt, aux_rvalid;
    logic [DW-1:0] aux_rdata;
    logic          MemWrite, MemRead;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
`ifdef ARB_STATS_EN
    logic [15:0]   cpu_stall_cnt, aux_stall_cnt;
`endif

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_lock   (aux_lock),
        .aux_gnt    (aux_gnt),
        .aux_rvalid (aux_rvalid),
        .aux_rdata  (aux_rdata),
`ifdef ARB_STATS_EN
        .cpu_stall_cnt (cpu_stall_cnt),
        .aux_stall_cnt (aux_stall_cnt),
`endif
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 CLK = ~CLK;

    assign read_data = ram[address];

    always @(posedge CLK) begin
        if (MemWrite) ram[address] <= write_data;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0; aux_lock = 0;
    endtask

    task automatic test_reset();
        RSTn = 0;
        idle_inputs();
        cpu_req = 1; cpu_addr = 10'h005; aux_req = 1; aux_addr = 10'h006;
        tick();
        tick();
        n_checks++;
        if (cpu_gnt !== 1'b0 || aux_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt: cpu_gnt=%b aux_gnt=%b expected 0 0", cpu_gnt, aux_gnt);
        end
        n_checks++;
        if (MemRead !== 1'b0 || MemWrite !== 1'b0 || address !== '0 || write_data !== '0) begin
            n_fail++; $display("FAIL reset_ram: rd=%b wr=%b addr=%h wd=%h expected all 0", MemRead, MemWrite, address, write_data);
        end
        n_checks++;
        if (cpu_rvalid !== 1'b0 || aux_rvalid !== 1'b0 || cpu_rdata !== '0 || aux_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rd: cpu_rv=%b aux_rv=%b cpu_rd=%h aux_rd=%h expected 0", cpu_rvalid, aux_rvalid, cpu_rdata, aux_rdata);
        end
        idle_inputs();
        RSTn = 1;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        #1;
        n_checks++;
        if (cpu_gnt !== 1'b1 || MemRead !== 1'b1 || MemWrite !== 1'b0 || address !== 10'h004) begin
            n_fail++; $display("FAIL cpu_read_grant: gnt=%b rd=%b wr=%b addr=%h expected 1 1 0 004", cpu_gnt, MemRead, MemWrite, address);
        end
        tick();
        cpu_req = 0;
        #1;
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL cpu_read_data: rvalid=%b rdata=%h expected 1 deadbeef", cpu_rvalid, cpu_rdata);
        end
        tick();
        n_checks++;
        if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL cpu_read_pulse: rvalid=%b rdata=%h expected 0 deadbeef", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_starvation();
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h001; cpu_wdata = 32'hAAAA_0001;
        aux_req = 1; aux_we = 1; aux_addr = 10'h002; aux_wdata = 32'hBBBB_0002;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (cpu_gnt !== (i != 4) || aux_gnt !== (i == 4)) begin
                n_fail++; $display("FAIL starve_cycle%0d: cpu_gnt=%b aux_gnt=%b expected %b %b", i, cpu_gnt, aux_gnt, (i != 4), (i == 4));
            end
            if (i == 4) begin
                n_checks++;
                if (MemWrite !== 1'b1 || address !== 10'h002 || write_data !== 32'hBBBB_0002) begin
                    n_fail++; $display("FAIL starve_aux_drive: wr=%b addr=%h wd=%h expected 1 002 bbbb0002", MemWrite, address, write_data);
                end
            end
            tick();
`ifdef ARB_STATS_EN
            if (i == 4) begin
                n_checks++;
                if (aux_stall_cnt !== 16'd4) begin
                    n_fail++; $display("FAIL aux_stall_cnt: got %0d expected 4", aux_stall_cnt);
                end
            end
`endif
        end
        idle_inputs();
        tick();
        n_checks++;
        if (ram[1] !== 32'hAAAA_0001 || ram[2] !== 32'hBBBB_0002) begin
            n_fail++; $display("FAIL starve_ram: ram1=%h ram2=%h expected aaaa0001 bbbb0002", ram[1], ram[2]);
        end
    endtask

    task automatic test_wait_clear();
        cpu_req = 1; cpu_we = 1; cpu_addr = 10'h010; cpu_wdata = 32'h1;
        aux_we = 1; aux_addr = 10'h011; aux_wdata = 32'h2;
        // aux requests 3 cycles, drops for 1, then needs a full 4 more denials
        for (int i = 0; i < 9; i++) begin
            aux_req = (i != 3);
            #1;
            n_checks++;
            if (aux_gnt !== (i == 8) || cpu_gnt !== (i != 8)) begin
                n_fail++; $display("FAIL wait_clear_cycle%0d: cpu_gnt=%b aux_gnt=%b expected %b %b", i, cpu_gnt, aux_gnt, (i != 8), (i == 8));
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_lock();
        aux_req = 1; aux_we = 1; aux_addr = 10'h008; aux_wdata = 32'h11; aux_lock = 1;
        #1;
        n_checks++;
        if (aux_gnt !== 1'b1 || MemWrite !== 1'b1 || address !== 10'h008) begin
            n_fail++; $display("FAIL lock_aux_grant: gnt=%b wr=%b addr=%h expected 1 1 008", aux_gnt, MemWrite, address);
        end
        tick();
        aux_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h008;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (cpu_gnt !== 1'b0 || MemRead !== 1'b0) begin
                n_fail++; $display("FAIL lock_block%0d: cpu_gnt=%b rd=%b expected 0 0", i, cpu_gnt, MemRead);
            end
            tick();
        end
        aux_req = 1; aux_we = 0;
        #1;
        n_checks++;
        if (aux_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            n_fail++; $display("FAIL lock_aux_again: aux_gnt=%b cpu_gnt=%b expected 1 0", aux_gnt, cpu_gnt);
        end
        tick();
        aux_req = 0; aux_lock = 0;
        #1;
        n_checks++;
        if (cpu_gnt !== 1'b0 || aux_rvalid !== 1'b1 || aux_rdata !== 32'h11) begin
            n_fail++; $display("FAIL lock_release: cpu_gnt=%b aux_rv=%b aux_rd=%h expected 0 1 00000011", cpu_gnt, aux_rvalid, aux_rdata);
        end
        tick();
        n_checks++;
        if (cpu_gnt !== 1'b1 || MemRead !== 1'b1 || address !== 10'h008) begin
            n_fail++; $display("FAIL lock_cpu_after: gnt=%b rd=%b addr=%h expected 1 1 008", cpu_gnt, MemRead, address);
        end
        tick();
        cpu_req = 0;
        #1;
        n_checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h11) begin
            n_fail++; $display("FAIL lock_cpu_data: rvalid=%b rdata=%h expected 1 00000011", cpu_rvalid, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        // write, read, write, read, read of addr 3
        logic          we_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] wd_v [5] = '{32'h3333_0003, 32'h0, 32'h0000_0055, 32'h0, 32'h0};
        logic          rv_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [DW-1:0] rd_exp [6] = '{32'h11, 32'h11, 32'h3333_0003, 32'h3333_0003, 32'h55, 32'h55};
        for (int i = 0; i < 6; i++) begin
            cpu_req = (i < 5); cpu_addr = 10'h003;
            cpu_we = (i < 5) ? we_v[i] : 1'b0;
            cpu_wdata = (i < 5) ? wd_v[i] : 32'h0;
            #1;
            if (i < 5) begin
                n_checks++;
                if (cpu_gnt !== 1'b1 || MemWrite !== we_v[i] || MemRead !== !we_v[i]) begin
                    n_fail++; $display("FAIL b2b_grant%0d: gnt=%b wr=%b rd=%b expected 1 %b %b", i, cpu_gnt, MemWrite, MemRead, we_v[i], !we_v[i]);
                end
            end
            n_checks++;
            if (cpu_rvalid !== rv_exp[i] || cpu_rdata !== rd_exp[i]) begin
                n_fail++; $display("FAIL b2b_ret%0d: rvalid=%b rdata=%h expected %b %h", i, cpu_rvalid, cpu_rdata, rv_exp[i], rd_exp[i]);
            end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: rvalid=%b expected 0", cpu_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        aux_req = 1; aux_we = 0; aux_addr = 10'h004; aux_lock = 1;
        #1;
        n_checks++;
        if (aux_gnt !== 1'b1 || MemRead !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_grant: gnt=%b rd=%b expected 1 1", aux_gnt, MemRead);
        end
        tick();
        aux_req = 0;
        RSTn = 0;
        #1;
        n_checks++;
        if (aux_rvalid !== 1'b1 || aux_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rstmid_pending: rvalid=%b rdata=%h expected 1 deadbeef", aux_rvalid, aux_rdata);
        end
        tick();
        n_checks++;
        if (aux_rvalid !== 1'b0 || aux_rdata !== '0 || MemRead !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_cleared: rvalid=%b rdata=%h rd=%b expected 0 0 0", aux_rvalid, aux_rdata, MemRead);
        end
        RSTn = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 10'h004;
        #1;
        n_checks++;
        if (cpu_gnt !== 1'b1 || aux_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_cpu_first: cpu_gnt=%b aux_gnt=%b expected 1 0", cpu_gnt, aux_gnt);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (cpu_gnt !== 1'b0 || aux_gnt !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0 ||
                address !== '0 || write_data !== '0 || cpu_rvalid !== 1'b0 || aux_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL idle%0d: gnt=%b%b rd=%b wr=%b addr=%h wd=%h rv=%b%b expected all 0",
                                   i, cpu_gnt, aux_gnt, MemRead, MemWrite, address, write_data, cpu_rvalid, aux_rvalid);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        ram[4] = 32'hDEADBEEF;
        test_reset();
        test_cpu_read();
        test_starvation();
        test_wait_clear();
        test_lock();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
